// File: rtl/bounce_gen.sv
// Emulates a chattering mechanical switch. On request it drives a pseudo-random
// bounce burst, holds the settled level, then pulses done.
module bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned MIN_HOLD      = 4,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic req,
  input  logic target,
  output logic switch_out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  // An all-zero Galois LFSR never leaves zero, so a zero seed is promoted.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] WIN_INIT  = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] SET_INIT  = 16'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  HOLD_BASE = 9'(MIN_HOLD - 1);

  state_t      state, state_nx;
  logic [15:0] lfsr;
  logic [15:0] win_cnt, win_nx;
  logic [15:0] set_cnt, set_nx;
  logic [8:0]  hold_cnt, hold_nx;
  logic        tgt, tgt_nx;
  logic        sw_nx, busy_nx, done_nx;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Level length is MIN_HOLD + (0..15); the counter holds length-1.
  function automatic logic [8:0] hold_load(input logic [3:0] r);
    return HOLD_BASE + {5'd0, r};
  endfunction

  always_comb begin
    state_nx = state;
    win_nx   = win_cnt;
    set_nx   = set_cnt;
    hold_nx  = hold_cnt;
    tgt_nx   = tgt;
    sw_nx    = switch_out;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (target != switch_out) begin
            state_nx = BOUNCE;
            tgt_nx   = target;
            sw_nx    = target;
            win_nx   = WIN_INIT;
            hold_nx  = hold_load(lfsr[3:0]);
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      BOUNCE: begin
        // Window expiry wins over a coincident hold expiry.
        if (win_cnt == 16'd0) begin
          state_nx = SETTLE;
          sw_nx    = tgt;
          set_nx   = SET_INIT;
          hold_nx  = 9'd0;
        end else begin
          win_nx = win_cnt - 16'd1;
          if (hold_cnt == 9'd0) begin
            sw_nx   = ~switch_out;
            hold_nx = hold_load(lfsr[3:0]);
          end else begin
            hold_nx = hold_cnt - 9'd1;
          end
        end
      end
      SETTLE: begin
        sw_nx = tgt;
        if (set_cnt == 16'd0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          set_nx = set_cnt - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      win_cnt    <= 16'd0;
      set_cnt    <= 16'd0;
      hold_cnt   <= 9'd0;
      tgt        <= INIT_LEVEL;
      switch_out <= INIT_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      lfsr       <= lfsr_adv(lfsr);
      win_cnt    <= win_nx;
      set_cnt    <= set_nx;
      hold_cnt   <= hold_nx;
      tgt        <= tgt_nx;
      switch_out <= sw_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: directed scenarios plus random requests and resets,
// checked against a waveform-level model of the bounce burst.
module tb_bounce_gen;

  localparam int          BC   = 64;
  localparam int          MH   = 4;
  localparam int          SC   = 32;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic        INIT = 1'b0;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic req = 1'b0;
  logic target = 1'b0;
  logic switch_out, busy, done;

  bounce_gen #(
    .BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .SETTLE_CYCLES(SC),
    .LFSR_SEED(SEED), .INIT_LEVEL(INIT)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .target(target),
    .switch_out(switch_out), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Model: queue of expected {switch_out, busy, done} after each edge of a request.
  logic [2:0]  exp_q[$];
  logic        m_sw, m_busy, m_done;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sw   = INIT;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_lfsr = SEED;
  endtask

  // Bounce burst as a list of level runs: each run lasts MH + (LFSR value at its
  // starting edge)[3:0] clocks, truncated at the window end; then the settle hold.
  task automatic plan(input logic tg);
    logic [15:0] lf[BC];
    int t;
    logic lvl;
    lf[0] = m_lfsr;
    for (int i = 1; i < BC; i++) lf[i] = lfsr_next(lf[i-1]);
    t = 0;
    lvl = tg;
    while (t < BC) begin
      int d;
      d = MH + int'(lf[t][3:0]);
      for (int k = 0; k < d && t < BC; k++) begin
        exp_q.push_back({lvl, 1'b1, 1'b0});
        t++;
      end
      lvl = ~lvl;
    end
    for (int i = 0; i < SC; i++) exp_q.push_back({tg, 1'b1, 1'b0});
    exp_q.push_back({tg, 1'b0, 1'b1});
  endtask

  // One clock: model consumes inputs at the edge, outputs compared 1ns later.
  task automatic tick();
    @(posedge CLK);
    if (!RST) begin
      if (exp_q.size() != 0) begin
        {m_sw, m_busy, m_done} = exp_q.pop_front();
      end else if (req && (target != m_sw)) begin
        plan(target);
        {m_sw, m_busy, m_done} = exp_q.pop_front();
      end else begin
        m_busy = 1'b0;
        m_done = req;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    #1;
    check("switch_out", 32'(switch_out), 32'(m_sw));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    @(negedge CLK);
  endtask

  // Reset pulse asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2 RST = 1'b1;
    #1;
    check("arst_sw", 32'(switch_out), 32'(INIT));
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    model_reset();
    tick();
    RST = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output int ticks);
    ticks = 0;
    while (!done && ticks < limit) begin
      tick();
      ticks++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  logic trace[256];
  int   cyc, run, toggles, ones, nd, tk;

  initial begin
    // Power-on reset
    RST = 1'b1;
    model_reset();
    #1;
    check("rst_sw", 32'(switch_out), 32'(INIT));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    RST = 1'b0;

    // Request on the very first edge after reset, target=1
    req = 1'b1; target = 1'b1;
    tick();
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_sw", 32'(switch_out), 32'd1);
    req = 1'b0;
    trace[0] = switch_out;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      if (cyc < 256) trace[cyc] = switch_out;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(1 + BC + SC));
    run = 1; toggles = 0;
    for (int i = 1; i < BC; i++) begin
      if (trace[i] != trace[i-1]) begin
        check("run_len_ok", 32'((run >= MH) && (run <= MH + 15)), 32'd1);
        toggles++;
        run = 1;
      end else begin
        run++;
      end
    end
    check("toggled", 32'(toggles > 0), 32'd1);
    ones = 0;
    for (int i = BC; i < BC + SC; i++) if (trace[i]) ones++;
    check("settle_high", 32'(ones), 32'(SC));

    // Request to 0 with ignored req pulses (target flipped) during busy
    req = 1'b1; target = 1'b0;
    tick();
    nd = 0;
    for (int i = 1; i < 150; i++) begin
      req    = (i == 10 || i == 40);
      target = (i == 10 || i == 40);
      tick();
      if (done) nd++;
    end
    check("one_done", 32'(nd), 32'd1);
    check("settled_lvl", 32'(switch_out), 32'd0);

    // Same-level request: immediate done, no activity
    req = 1'b1; target = 1'b0;
    tick();
    check("same_done", 32'(done), 32'd1);
    check("same_busy", 32'(busy), 32'd0);
    check("same_sw", 32'(switch_out), 32'd0);
    req = 1'b0;
    tick();

    // Abort mid-bounce, then a fresh request completes
    req = 1'b1; target = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    async_reset();
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    req = 1'b1; target = 1'b1;
    tick();
    req = 1'b0;
    run_to_done(200, tk);
    check("post_rst_lat", 32'(tk + 1), 32'(1 + BC + SC));
    check("post_rst_sw", 32'(switch_out), 32'd1);
    tick();

    // Random requests, targets and occasional async resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        req = 1'b0;
        async_reset();
      end else begin
        req    = ($urandom_range(0, 3) == 0);
        target = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64: length in clocks of the chatter window; legal range 1..65535.
REQ-002 Parameter MIN_HOLD, default 4: minimum clocks per chatter level; legal range 1..255.
REQ-003 Parameter SETTLE_CYCLES, default 32: clocks the settled level is held before done; legal range 1..65535.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a zero seed SHALL be replaced by 16'h0001.
REQ-005 Parameter INIT_LEVEL, default 1'b0: switch_out value at reset.
REQ-006 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 req  input  1  single-cycle request to drive a switch transition; sampled on CLK.
REQ-009 target  input  1  level to settle to; sampled only in the cycle req is accepted.
REQ-010 switch_out  output  1  emulated raw mechanical-switch signal, registered; feeds a debouncer under test.
REQ-011 busy  output  1  high while in BOUNCE or SETTLE.
REQ-012 done  output  1  one-cycle pulse when a request completes.

Function
REQ-013 The FSM SHALL have states IDLE, BOUNCE and SETTLE.
REQ-014 The LFSR SHALL be 16-bit Galois, mask 16'hB400, and advance every clock in every state.
REQ-015 IDLE, req=1, target != switch_out: next edge -> BOUNCE; switch_out=target; busy=1; window counter=BOUNCE_CYCLES-1; hold counter=MIN_HOLD+lfsr[3:0]-1.
REQ-016 IDLE, req=1, target == switch_out: remain in IDLE with no switch_out change; done=1 on the next cycle.
REQ-017 req while busy=1 SHALL be ignored, with no queuing and no effect on target capture.
REQ-018 BOUNCE: the window counter decrements every clock; the hold counter decrements every clock.
REQ-019 BOUNCE, hold counter==0 and window counter!=0: toggle switch_out; reload hold counter=MIN_HOLD+lfsr[3:0]-1. The hold counter SHALL be 9 bits wide with no overflow.
REQ-020 BOUNCE, window counter==0: next edge -> SETTLE; switch_out forced to the captured target; settle counter=SETTLE_CYCLES-1. This overrides a coincident hold expiry.
REQ-021 In SETTLE, switch_out SHALL remain at target constantly; the settle counter decrements each clock.
REQ-022 SETTLE, settle counter==0: next edge -> IDLE; busy=0; done=1 for exactly that one cycle.
REQ-023 Each switch_out level in BOUNCE SHALL last at least MIN_HOLD and at most MIN_HOLD+15 clocks, except the final level, which is truncated by window end.
REQ-024 From req acceptance to done, the request SHALL take exactly 1+BOUNCE_CYCLES+SETTLE_CYCLES clocks.
REQ-025 The captured target SHALL be held in a register; later changes on the target input SHALL be ignored until IDLE.
REQ-026 switch_out, busy and done SHALL be registered outputs with no combinational path from any input.

Reset
REQ-027 RST=1 SHALL immediately set the state to IDLE, switch_out=INIT_LEVEL, busy=0, done=0, lfsr=LFSR_SEED, and all counters to 0, regardless of clock.
REQ-028 RST asserted mid-BOUNCE or mid-SETTLE SHALL abort the request with no done pulse.
REQ-029 The first req SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-030 Defaults, reset, req=1 with target=1 for one cycle -> busy=1 and switch_out=1 next cycle; done pulses exactly 97 cycles after acceptance; switch_out=1 for the final 32 cycles.
REQ-031 Same run -> every high/low run inside the 64-cycle window is 4..19 clocks (final run excepted); at least one toggle occurs with the default seed.
REQ-032 switch_out=0, req=1 with target=0 -> no switch_out change; busy stays 0; done=1 on the following cycle.
REQ-033 req pulses at cycles 10 and 40 of a busy period, with target flipped -> ignored; the settled level equals the originally captured target; exactly one done pulse.
REQ-034 RST asserted asynchronously mid-BOUNCE, between clock edges -> switch_out=INIT_LEVEL and busy=0 before the next edge; no done pulse; a subsequent req completes normally.
REQ-035 Closed loop with the team's debouncer on switch_out, toggle target 1->0->1 -> the debouncer reports exactly one trans_up and one trans_dn per request.
